// File: rtl/spi_flash_arbiter.sv
// Round-robin arbiter sharing one SPI flash pin set between two controllers.
// It holds cs_n high for a guard interval between owners and force-releases an owner that keeps the bus too long.
module spi_flash_arbiter #(
  parameter logic [7:0]  CNT_GUARD_MAX   = 8'd4,
  parameter logic [25:0] CNT_TIMEOUT_MAX = 26'd50_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic req0,
  input  logic req1,
  input  logic sck0,
  input  logic cs0_n,
  input  logic mosi0,
  input  logic sck1,
  input  logic cs1_n,
  input  logic mosi1,
  output logic miso0,
  output logic miso1,
  output logic gnt0,
  output logic gnt1,
  output logic sck,
  output logic cs_n,
  output logic mosi,
  input  logic miso,
  output logic busy,
  output logic timeout,
  output logic timeout_id
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, GUARD} state_t;

  state_t      state;
  logic        last_gnt;
  logic        lock0, lock1;
  logic [7:0]  guard_cnt;
  logic [25:0] tmo_cnt;

  logic elig0, elig1, tmo_hit;
  logic g_id, g_req, g_sck, g_cs_n, g_mosi;

  assign elig0   = req0 && !lock0;
  assign elig1   = req1 && !lock1;
  assign tmo_hit = (CNT_TIMEOUT_MAX != '0) && (tmo_cnt == CNT_TIMEOUT_MAX);

  // Both grant states share one branch, so the owner's signals are selected here.
  assign g_id   = (state == GRANT1);
  assign g_req  = g_id ? req1  : req0;
  assign g_sck  = g_id ? sck1  : sck0;
  assign g_cs_n = g_id ? cs1_n : cs0_n;
  assign g_mosi = g_id ? mosi1 : mosi0;

  always_comb begin
    miso0 = 1'b0;
    miso1 = 1'b0;
    if (state == GRANT0) miso0 = miso;
    if (state == GRANT1) miso1 = miso;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      sck        <= 1'b0;
      cs_n       <= 1'b1;
      mosi       <= 1'b0;
      busy       <= 1'b0;
      timeout    <= 1'b0;
      timeout_id <= 1'b0;
      last_gnt   <= 1'b1;
      lock0      <= 1'b0;
      lock1      <= 1'b0;
      guard_cnt  <= '0;
      tmo_cnt    <= '0;
    end else begin
      timeout <= 1'b0;
      if (!req0) lock0 <= 1'b0;
      if (!req1) lock1 <= 1'b0;
      case (state)
        IDLE: begin
          sck       <= 1'b0;
          cs_n      <= 1'b1;
          mosi      <= 1'b0;
          guard_cnt <= '0;
          tmo_cnt   <= '0;
          if (elig0 && (!elig1 || last_gnt)) begin
            state    <= GRANT0;
            gnt0     <= 1'b1;
            last_gnt <= 1'b0;
            busy     <= 1'b1;
          end else if (elig1) begin
            state    <= GRANT1;
            gnt1     <= 1'b1;
            last_gnt <= 1'b1;
            busy     <= 1'b1;
          end
        end
        GRANT0, GRANT1: begin
          if (tmo_hit || !g_req) begin
            state     <= GUARD;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            sck       <= 1'b0;
            cs_n      <= 1'b1;
            mosi      <= 1'b0;
            guard_cnt <= '0;
            tmo_cnt   <= '0;
            if (tmo_hit) begin
              timeout    <= 1'b1;
              timeout_id <= g_id;
              // A requester that released on the timeout cycle is left unlocked.
              if (g_req) begin
                if (g_id) lock1 <= 1'b1;
                else      lock0 <= 1'b1;
              end
            end
          end else begin
            sck  <= g_sck;
            cs_n <= g_cs_n;
            mosi <= g_mosi;
            if (tmo_cnt != '1) tmo_cnt <= tmo_cnt + 26'd1;
          end
        end
        GUARD: begin
          sck  <= 1'b0;
          cs_n <= 1'b1;
          mosi <= 1'b0;
          if (guard_cnt == CNT_GUARD_MAX) begin
            state     <= IDLE;
            busy      <= 1'b0;
            guard_cnt <= '0;
            tmo_cnt   <= '0;
          end else begin
            guard_cnt <= guard_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
